// File: rtl/reg_wr_arbiter.sv
// Three-port register-file write arbiter with starvation-based preemption of port 0.
// Define REG_WR_ARB_SCOREBOARD_EN to build the busy-register scoreboard; otherwise busy_1/busy_2 are 0.
module reg_wr_arbiter #(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_valid,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic        wb_ready,
    input  logic        md_valid,
    input  logic [4:0]  md_addr,
    input  logic [31:0] md_data,
    output logic        md_ready,
    input  logic        ld_valid,
    input  logic [4:0]  ld_addr,
    input  logic [31:0] ld_data,
    output logic        ld_ready,
    input  logic        claim_valid,
    input  logic [4:0]  claim_addr,
    input  logic [4:0]  query_addr_1,
    input  logic [4:0]  query_addr_2,
    output logic        busy_1,
    output logic        busy_2,
    output logic        write_enable,
    output logic [4:0]  write_addr,
    output logic [31:0] write_data,
    output logic        stall_wb
);

    logic [1:0]  w_sec_valid;
    logic [1:0]  w_starved;
    logic [2:0]  w_grant;
    logic [2:0]  w_hs;
    logic [4:0]  w_sel_addr;
    logic [31:0] w_sel_data;

    // r_ptr == 0 prefers port 1 (md), r_ptr == 1 prefers port 2 (ld)
    logic        r_ptr;
    logic        r_we;
    logic [4:0]  r_waddr;
    logic [31:0] r_wdata;

    assign w_sec_valid = {ld_valid, md_valid};

    // Per-secondary-port wait counters; index 0 is md, index 1 is ld
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sec
            logic [3:0] r_wait;

            assign w_starved[gi] = w_sec_valid[gi] && (r_wait >= 4'(STARVE_LIMIT));

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_wait <= 4'd0;
                end else if (w_sec_valid[gi] && !w_hs[gi+1]) begin
                    r_wait <= (r_wait == 4'd15) ? 4'd15 : r_wait + 4'd1;
                end else begin
                    r_wait <= 4'd0;
                end
            end
        end
    endgenerate

    always_comb begin
        w_grant = 3'b000;
        if (&w_starved) begin
            if (r_ptr) w_grant[2] = 1'b1;
            else       w_grant[1] = 1'b1;
        end else if (w_starved[0]) begin
            w_grant[1] = 1'b1;
        end else if (w_starved[1]) begin
            w_grant[2] = 1'b1;
        end else if (wb_valid) begin
            w_grant[0] = 1'b1;
        end else if (&w_sec_valid) begin
            if (r_ptr) w_grant[2] = 1'b1;
            else       w_grant[1] = 1'b1;
        end else if (md_valid) begin
            w_grant[1] = 1'b1;
        end else if (ld_valid) begin
            w_grant[2] = 1'b1;
        end
    end

    // Readys are combinational, so they must be forced low while reset is held
    assign w_hs     = w_grant & {3{rst}};
    assign wb_ready = w_hs[0];
    assign md_ready = w_hs[1];
    assign ld_ready = w_hs[2];
    assign stall_wb = rst && wb_valid && !w_hs[0];

    always_comb begin
        w_sel_addr = wb_addr;
        w_sel_data = wb_data;
        if (w_hs[1]) begin
            w_sel_addr = md_addr;
            w_sel_data = md_data;
        end else if (w_hs[2]) begin
            w_sel_addr = ld_addr;
            w_sel_data = ld_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr <= 1'b0;
        end else if (w_hs[1]) begin
            r_ptr <= 1'b1;
        end else if (w_hs[2]) begin
            r_ptr <= 1'b0;
        end
    end

    // Address 0 is hardwired; its writes are consumed but never reach the register file
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_we    <= 1'b0;
            r_waddr <= 5'd0;
            r_wdata <= 32'd0;
        end else begin
            r_we <= (|w_hs) && (w_sel_addr != 5'd0);
            if (|w_hs) begin
                r_waddr <= w_sel_addr;
                r_wdata <= w_sel_data;
            end
        end
    end

    assign write_enable = r_we;
    assign write_addr   = r_waddr;
    assign write_data   = r_wdata;

`ifdef REG_WR_ARB_SCOREBOARD_EN
    logic [31:0] r_busy;
    logic [31:0] w_busy_next;
    logic        w_clr;
    logic [4:0]  w_clr_addr;

    assign w_clr      = w_hs[1] || w_hs[2];
    assign w_clr_addr = w_hs[1] ? md_addr : ld_addr;

    // A same-cycle claim beats a clear, so the set term is ORed in last
    generate
        for (gi = 0; gi < 32; gi++) begin : g_busy
            if (gi == 0) begin : g_zero
                assign w_busy_next[gi] = 1'b0;
            end else begin : g_bit
                assign w_busy_next[gi] =
                    (claim_valid && (claim_addr == 5'(gi))) ||
                    (r_busy[gi] && !(w_clr && (w_clr_addr == 5'(gi))));
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy <= 32'd0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

    assign busy_1 = (query_addr_1 != 5'd0) && r_busy[query_addr_1];
    assign busy_2 = (query_addr_2 != 5'd0) && r_busy[query_addr_2];
`else
    logic w_unused_claim;
    assign w_unused_claim = ^{claim_valid, claim_addr, query_addr_1, query_addr_2};
    assign busy_1 = 1'b0;
    assign busy_2 = 1'b0;
`endif

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Self-checking bench for reg_wr_arbiter: a per-cycle behavioural model plus directed scenarios
// with literal expectations.
module tb_reg_wr_arbiter;
    localparam int LIM = 8;
`ifdef REG_WR_ARB_SCOREBOARD_EN
    localparam bit SB_EN = 1'b1;
`else
    localparam bit SB_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid, md_valid, ld_valid, claim_valid;
    logic [4:0]  wb_addr, md_addr, ld_addr, claim_addr, query_addr_1, query_addr_2;
    logic [31:0] wb_data, md_data, ld_data;
    logic        wb_ready, md_ready, ld_ready, busy_1, busy_2, write_enable, stall_wb;
    logic [4:0]  write_addr;
    logic [31:0] write_data;

    int checks = 0;
    int errors = 0;

    reg_wr_arbiter #(.STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ready(wb_ready),
        .md_valid(md_valid), .md_addr(md_addr), .md_data(md_data), .md_ready(md_ready),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
        .claim_valid(claim_valid), .claim_addr(claim_addr),
        .query_addr_1(query_addr_1), .query_addr_2(query_addr_2),
        .busy_1(busy_1), .busy_2(busy_2),
        .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
        .stall_wb(stall_wb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model state: wait cycles per secondary port, preferred secondary, busy set, pending write
    int          m_wait [1:2] = '{0, 0};
    int          m_rr = 1;
    bit          m_busy [32];
    bit          e_we = 1'b0;
    logic [4:0]  e_wa = '0;
    logic [31:0] e_wd = '0;
    int          g_cur = -1;

    function automatic int expected_grant();
        int starved[$];
        if (md_valid && m_wait[1] >= LIM) starved.push_back(1);
        if (ld_valid && m_wait[2] >= LIM) starved.push_back(2);
        if (starved.size() == 2) return m_rr;
        if (starved.size() == 1) return starved[0];
        if (wb_valid) return 0;
        if (md_valid && ld_valid) return m_rr;
        if (md_valid) return 1;
        if (ld_valid) return 2;
        return -1;
    endfunction

    function automatic logic [4:0] port_addr(input int p);
        return (p == 0) ? wb_addr : (p == 1) ? md_addr : ld_addr;
    endfunction

    function automatic logic [31:0] port_data(input int p);
        return (p == 0) ? wb_data : (p == 1) ? md_data : ld_data;
    endfunction

    always @(negedge rst) begin
        m_wait[1] <= 0;
        m_wait[2] <= 0;
        m_rr      <= 1;
        e_we      <= 1'b0;
        for (int i = 0; i < 32; i++) m_busy[i] <= 1'b0;
    end

    // Compare process: outputs are stable mid-cycle
    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_wb_ready", wb_ready, 0);
            chk("rst_md_ready", md_ready, 0);
            chk("rst_ld_ready", ld_ready, 0);
            chk("rst_stall_wb", stall_wb, 0);
            chk("rst_write_enable", write_enable, 0);
            chk("rst_write_addr", write_addr, 0);
            chk("rst_write_data", write_data, 0);
            chk("rst_busy_1", busy_1, 0);
            chk("rst_busy_2", busy_2, 0);
            g_cur <= -1;
        end else begin
            int g;
            g = expected_grant();
            g_cur <= g;
            chk("wb_ready", wb_ready, g == 0);
            chk("md_ready", md_ready, g == 1);
            chk("ld_ready", ld_ready, g == 2);
            chk("stall_wb", stall_wb, wb_valid && g != 0);
            chk("write_enable", write_enable, e_we);
            if (e_we) begin
                chk("write_addr", write_addr, e_wa);
                chk("write_data", write_data, e_wd);
            end
            chk("busy_1", busy_1, SB_EN && query_addr_1 != 0 && m_busy[query_addr_1]);
            chk("busy_2", busy_2, SB_EN && query_addr_2 != 0 && m_busy[query_addr_2]);
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            e_we <= (g_cur >= 0) && (port_addr(g_cur) != 0);
            if (g_cur >= 0) begin
                e_wa <= port_addr(g_cur);
                e_wd <= port_data(g_cur);
            end
            m_wait[1] <= (md_valid && g_cur != 1) ? ((m_wait[1] < 15) ? m_wait[1] + 1 : 15) : 0;
            m_wait[2] <= (ld_valid && g_cur != 2) ? ((m_wait[2] < 15) ? m_wait[2] + 1 : 15) : 0;
            if (g_cur == 1) m_rr <= 2;
            if (g_cur == 2) m_rr <= 1;
            if (g_cur == 1 || g_cur == 2) m_busy[port_addr(g_cur)] <= 1'b0;
            // Later nonblocking write wins, so a same-cycle claim keeps the bit set
            if (claim_valid && claim_addr != 0) m_busy[claim_addr] <= 1'b1;
        end
    end

    task automatic idle();
        wb_valid = 0; md_valid = 0; ld_valid = 0; claim_valid = 0;
    endtask

    task automatic half();
        @(negedge clk); #1;
    endtask

    task automatic next();
        @(posedge clk); #1;
    endtask

    initial begin
        idle();
        wb_addr = 0; wb_data = 0; md_addr = 0; md_data = 0; ld_addr = 0; ld_data = 0;
        claim_addr = 0; query_addr_1 = 0; query_addr_2 = 0;
        rst = 0;
        wb_valid = 1; md_valid = 1;
        half();
        chk("hold_rst_wb_ready", wb_ready, 0);
        next(); next();
        rst = 1;

        // All three request together with clear counters: port 0 wins
        wb_valid = 1; wb_addr = 3; wb_data = 32'h1111_1111;
        md_valid = 1; md_addr = 4; md_data = 32'h4444_4444;
        ld_valid = 1; ld_addr = 6; ld_data = 32'h6666_6666;
        half();
        chk("all3_wb_ready", wb_ready, 1);
        chk("all3_md_ready", md_ready, 0);
        next();
        idle();
        half();
        chk("all3_we", write_enable, 1);
        chk("all3_waddr", write_addr, 5'd3);
        chk("all3_wdata", write_data, 32'h1111_1111);
        next();

        // Claim r5, then starve md behind a continuous wb stream
        claim_valid = 1; claim_addr = 5; query_addr_1 = 5; query_addr_2 = 6;
        half();
`ifdef REG_WR_ARB_SCOREBOARD_EN
        chk("claim5_before", busy_1, 0);
`endif
        next();
        claim_valid = 0;
        wb_valid = 1; wb_addr = 1;
        md_valid = 1; md_addr = 5; md_data = 32'hA5A5_0005;
        for (int k = 0; k <= 8; k++) begin
            wb_data = k;
            half();
            if (k < 8) begin
                chk("starve_wb_ready", wb_ready, 1);
                chk("starve_md_ready", md_ready, 0);
            end else begin
                chk("starve8_md_ready", md_ready, 1);
                chk("starve8_stall_wb", stall_wb, 1);
            end
`ifdef REG_WR_ARB_SCOREBOARD_EN
            chk("claim5_held", busy_1, 1);
`endif
            next();
        end
        idle();
        half();
        chk("starve_we", write_enable, 1);
        chk("starve_waddr", write_addr, 5'd5);
`ifdef REG_WR_ARB_SCOREBOARD_EN
        chk("claim5_cleared", busy_1, 0);
`endif
        next();

        // Claim r7, then claim and clear r7 in the same cycle
        claim_valid = 1; claim_addr = 7; query_addr_2 = 7;
        next();
        md_valid = 1; md_addr = 7; md_data = 32'h0000_0707;
        half();
        chk("sameclk_md_ready", md_ready, 1);
        next();
        idle();
        half();
`ifdef REG_WR_ARB_SCOREBOARD_EN
        chk("sameclk_busy7", busy_2, 1);
`endif
        next();
        md_valid = 1;
        next();
        idle();
        half();
`ifdef REG_WR_ARB_SCOREBOARD_EN
        chk("clear7_busy", busy_2, 0);
`endif
        next();

        // Lone ld grant moves the pointer to md, then md/ld alternate
        ld_valid = 1; ld_addr = 8; ld_data = 32'h0000_0808;
        half();
        chk("ld_alone_ready", ld_ready, 1);
        next();
        md_valid = 1; md_addr = 10; md_data = 32'h0000_0A0A;
        ld_valid = 1; ld_addr = 11; ld_data = 32'h0000_0B0B;
        for (int i = 0; i < 4; i++) begin
            half();
            chk("rr_md_ready", md_ready, (i % 2) == 0);
            chk("rr_ld_ready", ld_ready, (i % 2) == 1);
            next();
        end
        idle();
        next();

        // Write to r0 is consumed but suppressed
        wb_valid = 1; wb_addr = 0; wb_data = 32'hDEAD_BEEF;
        half();
        chk("r0_wb_ready", wb_ready, 1);
        next();
        idle();
        half();
        chk("r0_we", write_enable, 0);
        next();

        // Both secondaries starve behind wb; pointer (md) breaks the tie, then ld, then wb again
        wb_valid = 1; wb_addr = 2; wb_data = 32'h0000_0202;
        md_valid = 1; ld_valid = 1;
        for (int k = 0; k <= 10; k++) begin
            int ep;
            ep = (k == 8) ? 1 : (k == 9) ? 2 : 0;
            half();
            chk("bothstarve_wb", wb_ready, ep == 0);
            chk("bothstarve_md", md_ready, ep == 1);
            chk("bothstarve_ld", ld_ready, ep == 2);
            next();
        end
        idle();
        next();

        // Reset the cycle after an md handshake
        claim_valid = 1; claim_addr = 12; query_addr_1 = 12;
        next();
        claim_valid = 0;
        md_valid = 1; md_addr = 9; md_data = 32'h0000_0909;
        half();
        chk("prerst_md_ready", md_ready, 1);
        next();
        idle();
        half();
        chk("prerst_we", write_enable, 1);
        chk("prerst_waddr", write_addr, 5'd9);
`ifdef REG_WR_ARB_SCOREBOARD_EN
        chk("prerst_busy12", busy_1, 1);
`endif
        rst = 0;
        #1;
        chk("rst_async_we", write_enable, 0);
        chk("rst_async_busy12", busy_1, 0);
        next();
        rst = 1;
        md_valid = 1; ld_valid = 1;
        half();
        chk("postrst_ptr_md", md_ready, 1);
        chk("postrst_ptr_ld", ld_ready, 0);
        next();
        idle();
        half();
        next();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
